// File: rtl/assoc_cache_if.sv
// CPU request/response and memory handshake bundle for assoc_cache.
// The cache side uses the slave modport; the CPU/memory side uses master.
interface assoc_cache_if;
  logic        flush;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  flush, req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output flush, req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache.sv
// 2-way set-associative write-through data cache, one word per line, LRU
// replacement, refill/write over a req/ack memory port, saturating hit/miss counters.
module assoc_cache #(
  parameter int SET_BITS  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  assoc_cache_if.slave         bus,
  output logic [CNT_WIDTH-1:0] o_hit_count,
  output logic [CNT_WIDTH-1:0] o_miss_count
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [2:0]          r_state;
  logic [SETS-1:0]     r_valid0;
  logic [SETS-1:0]     r_valid1;
  logic [SETS-1:0]     r_lru;
  logic [TAG_W-1:0]    r_tag0  [SETS];
  logic [TAG_W-1:0]    r_tag1  [SETS];
  logic [31:0]         r_data0 [SETS];
  logic [31:0]         r_data1 [SETS];
  logic                r_we;
  logic [29:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_hit;
  logic                r_hit_way;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic [31:0]         r_resp_rdata;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [CNT_WIDTH-1:0] r_hit_cnt;
  logic [CNT_WIDTH-1:0] r_miss_cnt;

  logic [SET_BITS-1:0] w_in_set;
  logic [TAG_W-1:0]    w_in_tag;
  logic                w_in_hit0;
  logic                w_in_hit1;
  logic                w_in_hit;
  logic [31:0]         w_in_data;
  logic [SET_BITS-1:0] w_set;
  logic [TAG_W-1:0]    w_tag;
  logic                w_victim;
  logic                w_arr_wr;
  logic                w_arr_way;
  logic [31:0]         w_arr_data;

  // The tag compare runs on the incoming address so a load hit can answer in LOOKUP.
  assign w_in_set  = bus.req_addr[SET_BITS+1:2];
  assign w_in_tag  = bus.req_addr[31:SET_BITS+2];
  assign w_in_hit0 = r_valid0[w_in_set] && (r_tag0[w_in_set] == w_in_tag);
  assign w_in_hit1 = r_valid1[w_in_set] && (r_tag1[w_in_set] == w_in_tag);
  assign w_in_hit  = w_in_hit0 || w_in_hit1;
  assign w_in_data = w_in_hit1 ? r_data1[w_in_set] : r_data0[w_in_set];

  assign w_set    = r_addr[SET_BITS-1:0];
  assign w_tag    = r_addr[29:SET_BITS];
  assign w_victim = !r_valid0[w_set] ? 1'b0 : (!r_valid1[w_set] ? 1'b1 : r_lru[w_set]);

  assign bus.req_ready  = (r_state == S_IDLE) && !bus.flush;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = {r_addr, 2'b00};
  assign bus.mem_wdata  = r_wdata;
  assign o_hit_count    = r_hit_cnt;
  assign o_miss_count   = r_miss_cnt;

  // Select the tag/data array write: store hit in LOOKUP or refill on mem_ack.
  always_comb begin
    w_arr_wr   = 1'b0;
    w_arr_way  = 1'b0;
    w_arr_data = r_wdata;
    if (i_rst) begin
      w_arr_wr = 1'b0;
    end else if ((r_state == S_LOOKUP) && r_we && r_hit) begin
      w_arr_wr  = 1'b1;
      w_arr_way = r_hit_way;
    end else if ((r_state == S_REFILL) && bus.mem_ack) begin
      w_arr_wr   = 1'b1;
      w_arr_way  = w_victim;
      w_arr_data = bus.mem_rdata;
    end else begin
      w_arr_wr = 1'b0;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (w_arr_wr) begin
      if (w_arr_way) begin
        r_tag1[w_set]  <= w_tag;
        r_data1[w_set] <= w_arr_data;
      end else begin
        r_tag0[w_set]  <= w_tag;
        r_data0[w_set] <= w_arr_data;
      end
    end
  end

  // Control FSM, valid/LRU state, response and memory handshake registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_valid0     <= '0;
      r_valid1     <= '0;
      r_lru        <= '0;
      r_we         <= 1'b0;
      r_addr       <= 30'd0;
      r_wdata      <= 32'd0;
      r_hit        <= 1'b0;
      r_hit_way    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_hit_cnt    <= {CNT_WIDTH{1'b0}};
      r_miss_cnt   <= {CNT_WIDTH{1'b0}};
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.flush) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
          end else if (bus.req_valid) begin
            r_we      <= bus.req_we;
            r_addr    <= bus.req_addr[31:2];
            r_wdata   <= bus.req_wdata;
            r_hit     <= w_in_hit;
            r_hit_way <= w_in_hit1;
            if (!bus.req_we && w_in_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_hit   <= 1'b1;
              r_resp_rdata <= w_in_data;
            end
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (r_hit) begin
            if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + CNT_ONE;
            r_lru[w_set] <= ~r_hit_way;
          end else begin
            if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_ONE;
          end
          if (r_we) begin
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
            r_state   <= S_WRITE;
          end else if (r_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.mem_ack) begin
            if (w_victim) r_valid1[w_set] <= 1'b1;
            else          r_valid0[w_set] <= 1'b1;
            r_lru[w_set] <= ~w_victim;
            r_resp_rdata <= bus.mem_rdata;
            r_resp_valid <= 1'b1;
            r_resp_hit   <= r_hit;
            r_mem_req    <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= r_hit;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Randomized bench for assoc_cache against a recency-list cache model and a word memory.
// Two instances share stimulus: 16-bit counters and 2-bit saturating counters.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, req_valid, req_we, mem_ack;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic [15:0] hit_a, miss_a;
  logic [1:0]  hit_b, miss_b;

  always #5 clk = ~clk;

  assoc_cache_if u_if_a();
  assoc_cache_if u_if_b();

  assign u_if_a.flush = flush;     assign u_if_b.flush = flush;
  assign u_if_a.req_valid = req_valid; assign u_if_b.req_valid = req_valid;
  assign u_if_a.req_we = req_we;   assign u_if_b.req_we = req_we;
  assign u_if_a.req_addr = req_addr; assign u_if_b.req_addr = req_addr;
  assign u_if_a.req_wdata = req_wdata; assign u_if_b.req_wdata = req_wdata;
  assign u_if_a.mem_ack = mem_ack; assign u_if_b.mem_ack = mem_ack;
  assign u_if_a.mem_rdata = mem_rdata; assign u_if_b.mem_rdata = mem_rdata;

  assoc_cache #(.SET_BITS(3), .CNT_WIDTH(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .bus(u_if_a.slave),
    .o_hit_count(hit_a), .o_miss_count(miss_a));

  assoc_cache #(.SET_BITS(3), .CNT_WIDTH(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .bus(u_if_b.slave),
    .o_hit_count(hit_b), .o_miss_count(miss_b));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: memory image plus per-set list of resident lines, index 0 = least recent
  logic [31:0] mem [logic [29:0]];
  int          m_cnt  [8];
  logic [29:0] m_line [8][2];
  int          m_hits, m_misses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[15:0] ^ 16'h5A5A, w[15:0]};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 8; s++) m_cnt[s] = 0;
  endtask

  function automatic int model_find(input logic [29:0] w);
    int s = int'(w[2:0]);
    for (int i = 0; i < m_cnt[s]; i++)
      if (m_line[s][i] == w) return i;
    return -1;
  endfunction

  task automatic model_touch(input logic [29:0] w, input int pos);
    int s = int'(w[2:0]);
    if (m_cnt[s] == 2 && pos == 0) begin
      m_line[s][0] = m_line[s][1];
      m_line[s][1] = w;
    end
  endtask

  task automatic model_fill(input logic [29:0] w);
    int s = int'(w[2:0]);
    if (m_cnt[s] < 2) begin
      m_line[s][m_cnt[s]] = w;
      m_cnt[s]++;
    end else begin
      m_line[s][0] = m_line[s][1];
      m_line[s][1] = w;
    end
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, ".hit16"},  32'(hit_a),  32'(sat(m_hits, 65535)));
    check_eq({tag, ".miss16"}, 32'(miss_a), 32'(sat(m_misses, 65535)));
    check_eq({tag, ".hit2"},   32'(hit_b),  32'(sat(m_hits, 3)));
    check_eq({tag, ".miss2"},  32'(miss_b), 32'(sat(m_misses, 3)));
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [29:0] w = addr[31:2];
    int          pos = model_find(w);
    bit          exp_hit = (pos >= 0);
    int          t;
    int          d;
    @(negedge clk);
    check_eq("ready_idle", 32'(u_if_a.req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    check_eq("ready_busy", 32'(u_if_a.req_ready), 32'd0);
    if (exp_hit && !we) begin
      check_eq("hit_resp_valid", 32'(u_if_a.resp_valid), 32'd1);
      check_eq("hit_resp_hit", 32'(u_if_a.resp_hit), 32'd1);
      check_eq("hit_rdata", u_if_a.resp_rdata, mem_val(w));
      check_eq("hit_no_memreq", 32'(u_if_a.mem_req), 32'd0);
      model_touch(w, pos);
      m_hits++;
    end else begin
      check_eq("early_resp", 32'(u_if_a.resp_valid), 32'd0);
      t = 0;
      while (!u_if_a.mem_req && t < 4) begin @(negedge clk); t++; end
      check_eq("mem_req_seen", 32'(u_if_a.mem_req), 32'd1);
      check_eq("mem_we", 32'(u_if_a.mem_we), 32'(we));
      check_eq("mem_addr", u_if_a.mem_addr, {w, 2'b00});
      if (we) check_eq("mem_wdata", u_if_a.mem_wdata, wdata);
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      check_eq("mem_req_held", 32'(u_if_a.mem_req), 32'd1);
      check_eq("mem_addr_held", u_if_a.mem_addr, {w, 2'b00});
      mem_ack = 1'b1;
      mem_rdata = we ? $urandom : mem_val(w);
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      check_eq("resp_valid", 32'(u_if_a.resp_valid), 32'd1);
      check_eq("resp_hit", 32'(u_if_a.resp_hit), 32'(exp_hit));
      if (!we) check_eq("miss_rdata", u_if_a.resp_rdata, mem_val(w));
      check_eq("b_in_step", 32'(u_if_b.resp_valid), 32'd1);
      if (we) begin
        mem[w] = wdata;
        if (exp_hit) model_touch(w, pos);
      end else begin
        model_fill(w);
      end
      if (exp_hit) m_hits++;
      else m_misses++;
    end
    @(negedge clk);
    check_eq("resp_pulse_end", 32'(u_if_a.resp_valid), 32'd0);
    check_eq("mem_req_end", 32'(u_if_a.mem_req), 32'd0);
    check_eq("ready_back", 32'(u_if_a.req_ready), 32'd1);
    check_counters("cnt");
  endtask

  task automatic do_flush(input logic [31:0] addr);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    #1;
    check_eq("flush_ready", 32'(u_if_a.req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check_eq("flush_no_resp", 32'(u_if_a.resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("flush_no_memreq", 32'(u_if_a.mem_req), 32'd0);
    check_eq("flush_ready_back", 32'(u_if_a.req_ready), 32'd1);
    model_clear();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
  endtask

  initial begin
    int t;
    flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; mem_ack = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0;
    mem[30'h10] = 32'hDEAD_BEEF;
    do_reset();
    @(negedge clk);
    check_eq("rst_ready", 32'(u_if_a.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(u_if_a.resp_valid), 32'd0);
    check_eq("rst_resp_hit", 32'(u_if_a.resp_hit), 32'd0);
    check_eq("rst_mem_req", 32'(u_if_a.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(u_if_a.mem_we), 32'd0);
    check_eq("rst_rdata", u_if_a.resp_rdata, 32'd0);
    check_counters("rst");

    do_req(1'b0, 32'h0000_0040, 32'd0);
    check_eq("first_rdata", u_if_a.resp_rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0040, 32'd0);
    do_req(1'b0, 32'h0000_0240, 32'd0);
    do_req(1'b0, 32'h0000_0440, 32'd0);
    do_req(1'b0, 32'h0000_0240, 32'd0);
    do_req(1'b0, 32'h0000_0040, 32'd0);
    do_req(1'b1, 32'h0000_0240, 32'h1234_5678);
    do_req(1'b0, 32'h0000_0240, 32'd0);
    check_eq("store_hit_data", u_if_a.resp_rdata, 32'h1234_5678);
    do_req(1'b1, 32'h0000_0840, 32'hCAFE_0001);
    do_req(1'b0, 32'h0000_0840, 32'd0);
    do_flush(32'h0000_0240);
    do_req(1'b0, 32'h0000_0240, 32'd0);

    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = ({27'd0, 5'($urandom_range(0, 5))} << 5) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4) do_flush(a);
      else do_req($urandom_range(0, 99) < 30, a, $urandom);
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_107C;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!u_if_a.mem_req && t < 4) begin @(negedge clk); t++; end
    check_eq("rst_refill_req", 32'(u_if_a.mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_hits = 0;
    m_misses = 0;
    check_eq("rst_abandon", 32'(u_if_a.mem_req), 32'd0);
    check_eq("rst_abandon_resp", 32'(u_if_a.resp_valid), 32'd0);
    check_counters("rst_mid");
    do_req(1'b0, 32'h0000_0240, 32'd0);
    do_req(1'b0, 32'h0000_0040, 32'd0);
    do_req(1'b0, 32'h0000_107C, 32'd0);
    for (int i = 0; i < 5; i++) do_req(1'b0, 32'h0000_0040, 32'd0);
    check_eq("sat_hit2", 32'(hit_b), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
